// File: rtl/johnson_phase_monitor.sv
// Johnson-code phase monitor: decodes a 4-bit Johnson counter, classifies each
// sample (illegal / first / hold / advance / restart / sequence error), tracks
// lock and counts completed 8-phase cycles while locked.
// Ports:
//   clk, reset (async active-low)
//   din[3:0]        Johnson code from upstream counter
//   sample_en       din sampled on a rising edge only when 1
//   err_clr         clears err_sticky (a same-cycle set wins)
//   phase_onehot[7:0], phase_idx[2:0], phase_valid  decoded phase of last sample
//   locked          lock FSM is in LOCKED
//   illegal_pulse, seq_err_pulse, restart_pulse     per-sample classification
//   err_sticky      latched illegal/sequence error
//   cycle_tick      completed 8-phase cycle while locked
//   cycle_count     completed cycles, modulo 2^CNT_W
module johnson_phase_monitor #(
  parameter int unsigned LOCK_N = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       din,
  input  logic             sample_en,
  input  logic             err_clr,
  output logic [7:0]       phase_onehot,
  output logic [2:0]       phase_idx,
  output logic             phase_valid,
  output logic             locked,
  output logic             illegal_pulse,
  output logic             seq_err_pulse,
  output logic             restart_pulse,
  output logic             err_sticky,
  output logic             cycle_tick,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int unsigned CODE_W = 4;
  localparam int unsigned ADV_W  = 4;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned PH_N   = 8;

  typedef enum logic [1:0] {ST_UNLOCKED, ST_ACQUIRE, ST_LOCKED} state_t;
  typedef enum logic [2:0] {
    CL_ILLEGAL, CL_FIRST, CL_HOLD, CL_ADVANCE, CL_RESTART, CL_SEQERR
  } class_t;

  state_t              state;
  logic [ADV_W-1:0]    adv_cnt;
  logic                have_prev;
  logic [CODE_W-1:0]   prev_code;

  logic                legal_c;
  logic [IDX_W-1:0]    idx_c;
  logic [CODE_W-1:0]   succ_c;
  class_t              cls_c;
  logic                err_set_c;
  logic                cycle_done_c;

  // Decode din to a phase index; codes outside the Johnson ring are illegal.
  always_comb begin
    legal_c = 1'b1;
    idx_c   = '0;
    case (din)
      4'b0000: idx_c = IDX_W'(0);
      4'b1000: idx_c = IDX_W'(1);
      4'b1100: idx_c = IDX_W'(2);
      4'b1110: idx_c = IDX_W'(3);
      4'b1111: idx_c = IDX_W'(4);
      4'b0111: idx_c = IDX_W'(5);
      4'b0011: idx_c = IDX_W'(6);
      4'b0001: idx_c = IDX_W'(7);
      default: legal_c = 1'b0;
    endcase
  end

  // Priority classification of the current sample against the last legal code.
  always_comb begin
    succ_c = {~prev_code[0], prev_code[CODE_W-1:1]};
    cls_c  = CL_SEQERR;
    if (!legal_c)                 cls_c = CL_ILLEGAL;
    else if (!have_prev)          cls_c = CL_FIRST;
    else if (din == prev_code)    cls_c = CL_HOLD;
    else if (din == succ_c)       cls_c = CL_ADVANCE;
    else if (din == '0)           cls_c = CL_RESTART;
    err_set_c    = sample_en && ((cls_c == CL_ILLEGAL) || (cls_c == CL_SEQERR));
    cycle_done_c = sample_en && (cls_c == CL_ADVANCE) && (state == ST_LOCKED) &&
                   (prev_code == 4'b0001);
  end

  // Lock FSM, phase outputs, pulses and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_UNLOCKED;
      adv_cnt       <= '0;
      have_prev     <= 1'b0;
      prev_code     <= '0;
      phase_onehot  <= '0;
      phase_idx     <= '0;
      phase_valid   <= 1'b0;
      locked        <= 1'b0;
      illegal_pulse <= 1'b0;
      seq_err_pulse <= 1'b0;
      restart_pulse <= 1'b0;
      err_sticky    <= 1'b0;
      cycle_tick    <= 1'b0;
      cycle_count   <= '0;
    end else begin
      illegal_pulse <= 1'b0;
      seq_err_pulse <= 1'b0;
      restart_pulse <= 1'b0;
      cycle_tick    <= 1'b0;

      // A set in the same cycle as err_clr wins; err_clr ignores sample_en.
      if (err_set_c)    err_sticky <= 1'b1;
      else if (err_clr) err_sticky <= 1'b0;

      if (sample_en) begin
        phase_valid   <= legal_c;
        phase_idx     <= legal_c ? idx_c : '0;
        phase_onehot  <= legal_c ? (PH_N'(1) << idx_c) : '0;
        illegal_pulse <= (cls_c == CL_ILLEGAL);
        seq_err_pulse <= (cls_c == CL_SEQERR);
        restart_pulse <= (cls_c == CL_RESTART);

        // Illegal samples leave the reference code untouched.
        if (legal_c) begin
          prev_code <= din;
          have_prev <= 1'b1;
        end

        if (cycle_done_c) begin
          cycle_tick  <= 1'b1;
          cycle_count <= cycle_count + CNT_W'(1);
        end

        case (state)
          ST_UNLOCKED: begin
            if (legal_c) begin
              state   <= ST_ACQUIRE;
              adv_cnt <= '0;
            end
          end
          ST_ACQUIRE: begin
            case (cls_c)
              CL_ADVANCE: begin
                adv_cnt <= adv_cnt + ADV_W'(1);
                if (adv_cnt == ADV_W'(LOCK_N - 1)) begin
                  state  <= ST_LOCKED;
                  locked <= 1'b1;
                end
              end
              CL_RESTART: adv_cnt <= '0;
              CL_ILLEGAL, CL_SEQERR: begin
                state   <= ST_UNLOCKED;
                adv_cnt <= '0;
              end
              default: ;
            endcase
          end
          ST_LOCKED: begin
            if ((cls_c == CL_ILLEGAL) || (cls_c == CL_SEQERR)) begin
              state   <= ST_UNLOCKED;
              adv_cnt <= '0;
              locked  <= 1'b0;
            end
          end
          default: begin
            state   <= ST_UNLOCKED;
            adv_cnt <= '0;
            locked  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Self-checking bench for johnson_phase_monitor: directed scenarios with literal
// expectations plus a randomized walk checked every cycle against a phase-index
// reference model. A second instance with CNT_W=2 checks counter wrap.
module tb_johnson_phase_monitor;

  localparam int LOCK_N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] din = 4'b0000;
  logic       sample_en = 1'b0;
  logic       err_clr = 1'b0;

  logic [7:0]  phase_onehot;
  logic [2:0]  phase_idx;
  logic        phase_valid, locked, illegal_pulse, seq_err_pulse, restart_pulse;
  logic        err_sticky, cycle_tick;
  logic [15:0] cycle_count;

  logic [7:0]  phase_onehot2;
  logic [2:0]  phase_idx2;
  logic        phase_valid2, locked2, illegal_pulse2, seq_err_pulse2, restart_pulse2;
  logic        err_sticky2, cycle_tick2;
  logic [1:0]  cycle_count2;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  johnson_phase_monitor #(.LOCK_N(LOCK_N), .CNT_W(16)) dut (
    .clk(clk), .reset(rst_n), .din(din), .sample_en(sample_en), .err_clr(err_clr),
    .phase_onehot(phase_onehot), .phase_idx(phase_idx), .phase_valid(phase_valid),
    .locked(locked), .illegal_pulse(illegal_pulse), .seq_err_pulse(seq_err_pulse),
    .restart_pulse(restart_pulse), .err_sticky(err_sticky), .cycle_tick(cycle_tick),
    .cycle_count(cycle_count)
  );

  johnson_phase_monitor #(.LOCK_N(LOCK_N), .CNT_W(2)) dut2 (
    .clk(clk), .reset(rst_n), .din(din), .sample_en(sample_en), .err_clr(err_clr),
    .phase_onehot(phase_onehot2), .phase_idx(phase_idx2), .phase_valid(phase_valid2),
    .locked(locked2), .illegal_pulse(illegal_pulse2), .seq_err_pulse(seq_err_pulse2),
    .restart_pulse(restart_pulse2), .err_sticky(err_sticky2), .cycle_tick(cycle_tick2),
    .cycle_count(cycle_count2)
  );

  always #5 clk = ~clk;

  // Ring of legal codes indexed by phase; illegal codes listed for stimulus.
  logic [3:0] ring [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                           4'b1111, 4'b0111, 4'b0011, 4'b0001};
  logic [3:0] bad  [8] = '{4'b0010, 4'b0100, 4'b0101, 4'b0110,
                           4'b1001, 4'b1010, 4'b1011, 4'b1101};

  function automatic int phase_of(input logic [3:0] d);
    for (int k = 0; k < 8; k++) if (ring[k] == d) return k;
    return -1;
  endfunction

  // Reference model: phases as integers, successor = next ring position.
  bit m_have = 0;
  int m_prev = 0;
  int m_mode = 0;   // 0 unlocked, 1 acquiring, 2 locked
  int m_run  = 0;   // consecutive advances while acquiring
  int m_cycles = 0;
  logic [7:0] e_onehot = '0;
  int  e_idx = 0;
  bit  e_valid = 0, e_ill = 0, e_seq = 0, e_rst = 0, e_err = 0, e_tick = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_have = 0; m_prev = 0; m_mode = 0; m_run = 0; m_cycles = 0;
      e_onehot = '0; e_idx = 0; e_valid = 0; e_ill = 0; e_seq = 0; e_rst = 0;
      e_err = 0; e_tick = 0;
    end else begin
      int p;
      bit ill, first, hold, adv, rs, se;
      p = phase_of(din);
      ill = (p < 0);
      first = !ill && !m_have;
      hold  = !ill && !first && (p == m_prev);
      adv   = !ill && !first && !hold && (p == (m_prev + 1) % 8);
      rs    = !ill && !first && !hold && !adv && (p == 0);
      se    = !ill && !first && !hold && !adv && !rs;
      e_ill = 0; e_seq = 0; e_rst = 0; e_tick = 0;
      if (sample_en && (ill || se)) e_err = 1;
      else if (err_clr)             e_err = 0;
      if (sample_en) begin
        e_valid = !ill;
        e_idx   = ill ? 0 : p;
        e_onehot = ill ? 8'h00 : (8'h01 << p);
        e_ill = ill; e_seq = se; e_rst = rs;
        if (adv && m_prev == 7 && m_mode == 2) begin
          e_tick = 1;
          m_cycles++;
        end
        if (m_mode == 0) begin
          if (!ill) begin m_mode = 1; m_run = 0; end
        end else if (m_mode == 1) begin
          if (adv) begin
            m_run++;
            if (m_run == LOCK_N) m_mode = 2;
          end else if (rs) m_run = 0;
          else if (ill || se) begin m_mode = 0; m_run = 0; end
        end else begin
          if (ill || se) begin m_mode = 0; m_run = 0; end
        end
        if (!ill) begin m_prev = p; m_have = 1; end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the sampling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_onehot",  32'(phase_onehot), 32'(e_onehot));
      chk("m_idx",     32'(phase_idx), 32'(e_idx));
      chk("m_valid",   32'(phase_valid), 32'(e_valid));
      chk("m_locked",  32'(locked), 32'(m_mode == 2));
      chk("m_illegal", 32'(illegal_pulse), 32'(e_ill));
      chk("m_seqerr",  32'(seq_err_pulse), 32'(e_seq));
      chk("m_restart", 32'(restart_pulse), 32'(e_rst));
      chk("m_err",     32'(err_sticky), 32'(e_err));
      chk("m_tick",    32'(cycle_tick), 32'(e_tick));
      chk("m_count",   32'(cycle_count), 32'(m_cycles % 65536));
      chk("m_count2",  32'(cycle_count2), 32'(m_cycles % 4));
      chk("m_tick2",   32'(cycle_tick2), 32'(e_tick));
    end
  end

  task automatic samp(input logic [3:0] d, input logic en = 1'b1, input logic clr = 1'b0);
    din = d; sample_en = en; err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_onehot"}, 32'(phase_onehot), 0);
    chk({tag, "_idx"},    32'(phase_idx), 0);
    chk({tag, "_valid"},  32'(phase_valid), 0);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_pulses"}, 32'({illegal_pulse, seq_err_pulse, restart_pulse, cycle_tick}), 0);
    chk({tag, "_err"},    32'(err_sticky), 0);
    chk({tag, "_count"},  32'(cycle_count), 0);
  endtask

  initial begin
    int cur;
    #12;
    all_zero("rst");
    cmp_en = 1'b1;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Lock acquisition: 4 advances after the first sample.
    samp(4'b0000); samp(4'b1000); samp(4'b1100); samp(4'b1110);
    chk("lock_before", 32'(locked), 0);
    samp(4'b1111);
    chk("lock_after", 32'(locked), 1);
    chk("lock_onehot", 32'(phase_onehot), 32'h10);

    // Three completed cycles.
    samp(4'b0111); samp(4'b0011); samp(4'b0001); samp(4'b0000);
    chk("cyc1_idx", 32'(phase_idx), 0);
    chk("cyc1_tick", 32'(cycle_tick), 1);
    for (int r = 0; r < 2; r++)
      for (int k = 1; k <= 8; k++) samp(ring[k % 8]);
    chk("cyc3_count", 32'(cycle_count), 3);

    // Restart from 1110, then repeated 0000 holds.
    samp(4'b1000); samp(4'b1100); samp(4'b1110); samp(4'b0000);
    chk("restart_pulse", 32'(restart_pulse), 1);
    chk("restart_locked", 32'(locked), 1);
    chk("restart_count", 32'(cycle_count), 3);
    samp(4'b0000); samp(4'b0000);
    chk("hold_pulses", 32'({illegal_pulse, seq_err_pulse, restart_pulse}), 0);

    // Illegal code while locked, then a sequence error against 1111.
    samp(4'b1000); samp(4'b1100); samp(4'b1110); samp(4'b1111);
    samp(4'b0101);
    chk("ill_pulse", 32'(illegal_pulse), 1);
    chk("ill_valid", 32'(phase_valid), 0);
    chk("ill_onehot", 32'(phase_onehot), 0);
    chk("ill_locked", 32'(locked), 0);
    chk("ill_err", 32'(err_sticky), 1);
    samp(4'b0001);
    chk("seq_pulse", 32'(seq_err_pulse), 1);

    // err_clr loses to a same-cycle set, then clears alone.
    samp(4'b1010, 1'b1, 1'b1);
    chk("clr_same", 32'(err_sticky), 1);
    samp(4'b1010, 1'b0, 1'b1);
    chk("clr_alone", 32'(err_sticky), 0);

    // Fourth cycle wraps the 2-bit counter.
    samp(4'b0000);
    for (int k = 1; k <= 8; k++) samp(ring[k % 8]);
    chk("wrap_count16", 32'(cycle_count), 4);
    chk("wrap_count2", 32'(cycle_count2), 0);

    // Asynchronous reset in the middle of an acquisition.
    samp(4'b0101); samp(4'b1000); samp(4'b1100);
    #2 rst_n = 1'b0;
    #1 all_zero("arst");
    #2 rst_n = 1'b1;
    samp(4'b1110);
    chk("post_valid", 32'(phase_valid), 1);
    samp(4'b1111); samp(4'b0111); samp(4'b0011);
    chk("post_unlocked", 32'(locked), 0);
    samp(4'b0001);
    chk("post_locked", 32'(locked), 1);

    // Randomized walk, mostly advancing.
    cur = 7;
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic en, clr;
      logic [3:0] d;
      r = $urandom_range(0, 99);
      en = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 19) == 0);
      if (r < 62)      begin cur = (cur + 1) % 8; d = ring[cur]; end
      else if (r < 72) d = ring[cur];
      else if (r < 78) begin cur = 0; d = ring[0]; end
      else if (r < 84) d = bad[$urandom_range(0, 7)];
      else if (r < 90) begin cur = $urandom_range(0, 7); d = ring[cur]; end
      else if (r < 91) begin
        samp(ring[cur], en, clr);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        continue;
      end else begin cur = (cur + 1) % 8; d = ring[cur]; end
      samp(d, en, clr);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
